// File: rtl/gf12_sram_sp_8192x64_hd_if.sv
// rtl/gf12_sram_sp_8192x64_hd_if.sv - access port bundle for the 8192x64 single-port SRAM
interface gf12_sram_sp_8192x64_hd_if;
  logic        CE0;
  logic [12:0] A0;
  logic [63:0] D0;
  logic        WE0;
  logic [63:0] WEM0;
  logic [63:0] Q0;

  modport master (output CE0, A0, D0, WE0, WEM0, input Q0);
  modport slave  (input CE0, A0, D0, WE0, WEM0, output Q0);
endinterface

// File: rtl/gf12_sram_sp_8192x64_hd.sv
// rtl/gf12_sram_sp_8192x64_hd - behavioural 8192x64 single-port SRAM with per-bit write mask
module gf12_sram_sp_8192x64_hd (
  input  logic                          CLK,
  input  logic                          RSTN,
  gf12_sram_sp_8192x64_hd_if.slave      bus
);

  logic [63:0] mem [0:8191];
  logic [63:0] q_q;
  logic [63:0] q_d;
  logic        ctl_unknown;
  logic        wr_en;

  // Unknown control only matters to the model; synthesis sees it as constant 0.
  assign ctl_unknown = $isunknown(bus.CE0) || (bus.CE0 === 1'b1 && $isunknown(bus.WE0));
  assign wr_en       = RSTN && bus.CE0 && bus.WE0;

  always_comb begin
    q_d = q_q;
    if (ctl_unknown) begin
      q_d = 'x;
    end else if (bus.CE0 && !bus.WE0) begin
      q_d = mem[bus.A0];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      q_q <= 64'h0;
    end else begin
      q_q <= q_d;
    end
  end

  // Array is never reset; a write on a reset edge is dropped.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[bus.A0] <= (mem[bus.A0] & ~bus.WEM0) | (bus.D0 & bus.WEM0);
    end else if (RSTN && bus.CE0 === 1'b1 && $isunknown(bus.WE0)) begin
      mem[bus.A0] <= (mem[bus.A0] & ~bus.WEM0) | ({64{1'bx}} & bus.WEM0);
    end
  end

  assign bus.Q0 = q_q;

endmodule

// File: tb/tb_gf12_sram_sp_8192x64_hd.sv
// tb/tb_gf12_sram_sp_8192x64_hd.sv - randomized self-checking bench against an associative-array memory model
module tb_gf12_sram_sp_8192x64_hd;

  logic CLK = 1'b0;
  logic RSTN;
  int   total = 0;
  int   bad = 0;

  gf12_sram_sp_8192x64_hd_if sif ();

  gf12_sram_sp_8192x64_hd dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (sif)
  );

  always #5 CLK = ~CLK;

  logic [63:0] ref_mem [bit [12:0]];
  logic [63:0] exp_q;

  // One clock of stimulus; the model applies the access rules at the edge.
  task automatic cyc(input logic ce, input logic we, input logic [12:0] a,
                     input logic [63:0] d, input logic [63:0] wem);
    sif.CE0  = ce;
    sif.WE0  = we;
    sif.A0   = a;
    sif.D0   = d;
    sif.WEM0 = wem;
    @(posedge CLK);
    if (!RSTN) begin
      exp_q = 64'h0;
    end else if (ce && we) begin
      if (ref_mem.exists(a)) ref_mem[a] = (ref_mem[a] & ~wem) | (d & wem);
      else                   ref_mem[a] = d & wem;
    end else if (ce) begin
      exp_q = ref_mem[a];
    end
    #1;
  endtask

  task automatic test_reset;
    RSTN = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, 13'h0005, 64'h0, 64'h0);
      total++;
      if (sif.Q0 !== 64'h0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got=%h want=%h", i, sif.Q0, 64'h0);
      end
    end
    RSTN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'($urandom), 13'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
      total++;
      if (sif.Q0 !== 64'h0) begin
        bad++;
        $display("FAIL reset_release_idle cyc=%0d got=%h want=%h", i, sif.Q0, 64'h0);
      end
    end
  endtask

  task automatic test_full_rw;
    cyc(1'b1, 1'b1, 13'h0000, 64'hDEADBEEF_01234567, '1);
    cyc(1'b1, 1'b1, 13'h1FFF, 64'hA5A5A5A5_A5A5A5A5, '1);
    cyc(1'b1, 1'b0, 13'h0000, 64'h0, 64'h0);
    total++;
    if (sif.Q0 !== 64'hDEADBEEF_01234567) begin
      bad++;
      $display("FAIL full_read_0 got=%h want=%h", sif.Q0, 64'hDEADBEEF_01234567);
    end
    cyc(1'b1, 1'b0, 13'h1FFF, 64'h0, 64'h0);
    total++;
    if (sif.Q0 !== 64'hA5A5A5A5_A5A5A5A5) begin
      bad++;
      $display("FAIL full_read_1fff got=%h want=%h", sif.Q0, 64'hA5A5A5A5_A5A5A5A5);
    end
  endtask

  task automatic test_mask;
    cyc(1'b1, 1'b1, 13'h0123, 64'hFFFF_FFFF_FFFF_FFFF, '1);
    cyc(1'b1, 1'b1, 13'h0123, 64'h0, 64'h0000_0000_FFFF_0000);
    cyc(1'b1, 1'b0, 13'h0123, 64'h0, 64'h0);
    total++;
    if (sif.Q0 !== 64'hFFFF_FFFF_0000_FFFF) begin
      bad++;
      $display("FAIL bit_mask got=%h want=%h", sif.Q0, 64'hFFFF_FFFF_0000_FFFF);
    end
    for (int i = 0; i < 8; i++) begin
      logic [63:0] d, m;
      d = {$urandom, $urandom};
      m = {$urandom, $urandom};
      cyc(1'b1, 1'b1, 13'h0123, d, m);
      cyc(1'b1, 1'b0, 13'h0123, 64'h0, 64'h0);
      total++;
      if (sif.Q0 !== exp_q) begin
        bad++;
        $display("FAIL bit_mask_rand i=%0d got=%h want=%h", i, sif.Q0, exp_q);
      end
    end
  endtask

  task automatic test_hold;
    logic [63:0] x1;
    logic [12:0] chk [3];
    chk = '{13'h0000, 13'h1FFF, 13'h0123};
    cyc(1'b1, 1'b0, 13'h0000, 64'h0, 64'h0);
    x1 = 64'hDEADBEEF_01234567;
    cyc(1'b1, 1'b1, 13'h0777, 64'h1234_5678_9ABC_DEF0, '1);
    total++;
    if (sif.Q0 !== x1) begin
      bad++;
      $display("FAIL hold_on_write got=%h want=%h", sif.Q0, x1);
    end
    for (int i = 0; i < 20; i++) begin
      sif.CE0 = 1'b0;
      sif.WE0 = 1'($urandom);
      sif.A0  = chk[i % 3];
      sif.D0  = {$urandom, $urandom};
      sif.WEM0 = '1;
      @(posedge CLK);
      #1;
      total++;
      if (sif.Q0 !== x1) begin
        bad++;
        $display("FAIL hold_ce0_low i=%0d got=%h want=%h", i, sif.Q0, x1);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, chk[i], 64'h0, 64'h0);
      total++;
      if (sif.Q0 !== ref_mem[chk[i]]) begin
        bad++;
        $display("FAIL idle_readback a=%h got=%h want=%h", chk[i], sif.Q0, ref_mem[chk[i]]);
      end
    end
    cyc(1'b1, 1'b1, 13'h0123, 64'h0, 64'h0);
    cyc(1'b1, 1'b0, 13'h0123, 64'h0, 64'h0);
    total++;
    if (sif.Q0 !== exp_q) begin
      bad++;
      $display("FAIL zero_mask_noop got=%h want=%h", sif.Q0, exp_q);
    end
  endtask

  task automatic test_raw;
    logic [12:0] pool [32];
    cyc(1'b1, 1'b1, 13'h0042, 64'h1, '1);
    cyc(1'b1, 1'b0, 13'h0042, 64'h0, 64'h0);
    total++;
    if (sif.Q0 !== 64'h1) begin
      bad++;
      $display("FAIL read_after_write got=%h want=%h", sif.Q0, 64'h1);
    end
    for (int i = 0; i < 32; i++) begin
      pool[i] = 13'(13'h0800 + i * 37);
      cyc(1'b1, 1'b1, pool[i], {$urandom, $urandom}, '1);
    end
    for (int i = 0; i < 1000; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom), pool[$urandom_range(0, 31)],
          {$urandom, $urandom}, {$urandom, $urandom});
      total++;
      if (sif.Q0 !== exp_q) begin
        bad++;
        $display("FAIL random_traffic cyc=%0d got=%h want=%h", i, sif.Q0, exp_q);
      end
    end
  endtask

  task automatic test_reset_traffic;
    logic [63:0] old_v;
    old_v = {$urandom, $urandom};
    cyc(1'b1, 1'b1, 13'h0010, old_v, '1);
    cyc(1'b1, 1'b0, 13'h0010, 64'h0, 64'h0);
    RSTN = 1'b0;
    cyc(1'b1, 1'b1, 13'h0010, ~old_v, '1);
    total++;
    if (sif.Q0 !== 64'h0) begin
      bad++;
      $display("FAIL reset_during_write_q got=%h want=%h", sif.Q0, 64'h0);
    end
    cyc(1'b1, 1'b0, 13'h0010, 64'h0, 64'h0);
    total++;
    if (sif.Q0 !== 64'h0) begin
      bad++;
      $display("FAIL reset_during_read_q got=%h want=%h", sif.Q0, 64'h0);
    end
    RSTN = 1'b1;
    cyc(1'b1, 1'b0, 13'h0010, 64'h0, 64'h0);
    total++;
    if (sif.Q0 !== old_v) begin
      bad++;
      $display("FAIL reset_write_discarded got=%h want=%h", sif.Q0, old_v);
    end
  endtask

  initial begin
    RSTN = 1'b0;
    exp_q = 64'h0;
    sif.CE0 = 1'b0;
    sif.WE0 = 1'b0;
    sif.A0 = '0;
    sif.D0 = '0;
    sif.WEM0 = '0;
    test_reset();
    test_full_rw();
    test_mask();
    test_hold();
    test_raw();
    test_reset_traffic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
